// File: rtl/calc_ctrl.sv
// Keypad calculator sequencer: builds two decimal operands from key events, evaluates
// + - * / (multi-cycle restoring divide) and drives registered display/status outputs.
module calc_ctrl #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned W      = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_flag,
   input  logic [3:0]       key_data,
   output logic [2*W-1:0]   disp_val,
   output logic             disp_neg,
   output logic             err,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CntW    = $clog2(DIGITS + 1);
   localparam int unsigned DivCntW = $clog2(W);
   localparam logic [W-1:0] Ten    = W'(10);

   typedef enum logic [2:0] {
      StAEnt, StOpWait, StBEnt, StCalc, StResult, StError
   } state_e;

   typedef enum logic [1:0] {OpAdd, OpSub, OpMul, OpDiv} op_e;

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [W-1:0]        a_q, a_d, b_q, b_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [2*W-1:0]      r_q, r_d;
   logic                neg_q, neg_d;
   logic [W-1:0]        div_rem_q, div_rem_d, div_quo_q, div_quo_d;
   logic [DivCntW-1:0]  div_cnt_q, div_cnt_d;
   logic [2*W-1:0]      disp_d;

   logic                is_digit, is_op, is_eq, is_clr;
   logic [W-1:0]        digit;
   logic [W:0]          rem_sh;
   logic                div_ge;
   logic [W-1:0]        quo_nx;

   always_comb begin
      is_digit = key_flag && (key_data < 4'd10);
      is_op    = key_flag && (key_data >= 4'd10) && (key_data <= 4'd13);
      is_eq    = key_flag && (key_data == 4'd14);
      is_clr   = key_flag && (key_data == 4'd15);
      digit    = W'(key_data);
   end

   // One restoring-divide step: shift next dividend bit into the partial remainder.
   always_comb begin
      rem_sh = {div_rem_q, div_quo_q[W-1]};
      div_ge = (rem_sh >= {1'b0, b_q});
      quo_nx = {div_quo_q[W-2:0], div_ge};
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      r_d       = r_q;
      neg_d     = neg_q;
      div_rem_d = div_rem_q;
      div_quo_d = div_quo_q;
      div_cnt_d = div_cnt_q;

      case (state_q)
         StAEnt: begin
            if (is_digit && (cnt_q < CntW'(DIGITS))) begin
               a_d   = a_q * Ten + digit;
               cnt_d = cnt_q + CntW'(1);
            end else if (is_op) begin
               op_d    = op_e'(key_data[1:0] + 2'd2);
               cnt_d   = '0;
               state_d = StOpWait;
            end
         end
         StOpWait: begin
            if (is_digit) begin
               b_d     = digit;
               cnt_d   = CntW'(1);
               state_d = StBEnt;
            end else if (is_op) begin
               op_d = op_e'(key_data[1:0] + 2'd2);
            end
         end
         StBEnt: begin
            if (is_digit && (cnt_q < CntW'(DIGITS))) begin
               b_d   = b_q * Ten + digit;
               cnt_d = cnt_q + CntW'(1);
            end else if (is_eq) begin
               div_rem_d = '0;
               div_quo_d = a_q;
               div_cnt_d = '0;
               state_d   = StCalc;
            end
         end
         StCalc: begin
            neg_d = 1'b0;
            unique case (op_q)
               OpAdd: begin
                  r_d     = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
                  state_d = StResult;
               end
               OpSub: begin
                  if (a_q >= b_q) begin
                     r_d = {{W{1'b0}}, a_q - b_q};
                  end else begin
                     r_d   = {{W{1'b0}}, b_q - a_q};
                     neg_d = 1'b1;
                  end
                  state_d = StResult;
               end
               OpMul: begin
                  r_d     = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
                  state_d = StResult;
               end
               OpDiv: begin
                  if (b_q == '0) begin
                     state_d = StError;
                  end else begin
                     div_rem_d = div_ge ? W'(rem_sh - {1'b0, b_q}) : rem_sh[W-1:0];
                     div_quo_d = quo_nx;
                     div_cnt_d = div_cnt_q + DivCntW'(1);
                     if (div_cnt_q == DivCntW'(W - 1)) begin
                        r_d     = {{W{1'b0}}, quo_nx};
                        state_d = StResult;
                     end
                  end
               end
            endcase
         end
         StResult, StError: begin
            if (is_digit) begin
               a_d     = digit;
               b_d     = '0;
               cnt_d   = CntW'(1);
               neg_d   = 1'b0;
               state_d = StAEnt;
            end
         end
         default: state_d = StAEnt;
      endcase

      // Clear is honoured everywhere except mid-calculation.
      if (is_clr && (state_q != StCalc)) begin
         state_d   = StAEnt;
         op_d      = OpAdd;
         a_d       = '0;
         b_d       = '0;
         cnt_d     = '0;
         r_d       = '0;
         neg_d     = 1'b0;
         div_rem_d = '0;
         div_quo_d = '0;
         div_cnt_d = '0;
      end
   end

   always_comb begin
      case (state_d)
         StAEnt, StOpWait: disp_d = {{W{1'b0}}, a_d};
         StBEnt, StCalc:   disp_d = {{W{1'b0}}, b_d};
         StResult:         disp_d = r_d;
         default:          disp_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StAEnt;
         op_q      <= OpAdd;
         a_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         r_q       <= '0;
         neg_q     <= 1'b0;
         div_rem_q <= '0;
         div_quo_q <= '0;
         div_cnt_q <= '0;
         disp_val  <= '0;
         disp_neg  <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         r_q       <= r_d;
         neg_q     <= neg_d;
         div_rem_q <= div_rem_d;
         div_quo_q <= div_quo_d;
         div_cnt_q <= div_cnt_d;
         disp_val  <= disp_d;
         disp_neg  <= (state_d == StResult) && neg_d;
         err       <= (state_d == StError);
         busy      <= (state_d == StCalc);
         done      <= (state_q == StCalc) && (state_d == StResult);
      end
   end

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: expected results are queued when '=' is pressed and
// compared (value, sign, completion cycle) when done pulses.
module tb_calc_ctrl;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned W      = 14;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            key_flag;
   logic [3:0]      key_data;
   logic [2*W-1:0]  disp_val;
   logic            disp_neg, err, busy, done;

   calc_ctrl #(.DIGITS(DIGITS), .W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_flag (key_flag),
      .key_data (key_data),
      .disp_val (disp_val),
      .disp_neg (disp_neg),
      .err      (err),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] val;
      logic           neg;
      int             cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Result monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         check("done_one_cycle", prev_done, 0);
         if (sb.size() == 0) begin
            check("spurious_done", done, 0);
         end else begin
            mon_e = sb.pop_front();
            check("result_val", disp_val, mon_e.val);
            check("result_neg", disp_neg, mon_e.neg);
            check("done_cycle", cyc, mon_e.cyc);
            check("err_on_done", err, 0);
         end
      end
      prev_done = done;
   end

   // Caller is at a negedge; returns at the negedge after the sampling edge.
   task automatic press(input logic [3:0] k);
      key_flag = 1'b1;
      key_data = k;
      @(negedge clk);
      key_flag = 1'b0;
   endtask

   task automatic press_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         byte        c;
         logic [3:0] k;
         c = s[i];
         case (c)
            "+":     k = 4'd10;
            "-":     k = 4'd11;
            "*":     k = 4'd12;
            "/":     k = 4'd13;
            "=":     k = 4'd14;
            "C":     k = 4'd15;
            default: k = 4'(c - 8'd48);
         endcase
         press(k);
      end
   endtask

   task automatic calc(input string s, input logic [2*W-1:0] v, input logic n, input int lat);
      press_str(s);
      press(4'd14);
      sb.push_back('{val: v, neg: n, cyc: cyc + lat});
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
      check("done_timeout", sb.size(), 0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_val"}, disp_val, 0);
      check({tag, "_neg"}, disp_neg, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      key_flag = 1'b0;
      key_data = 4'd0;
      repeat (3) @(negedge clk);
      check_idle("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("after_reset");

      calc("1+9", 10, 1'b0, 1);
      check("add_busy", busy, 1);
      wait_done();
      check("add_busy_after", busy, 0);
      press_str("C");
      check("clear_val", disp_val, 0);

      calc("9-1", 8, 1'b0, 1);
      wait_done();
      press_str("C");
      calc("9*1", 9, 1'b0, 1);
      wait_done();
      press_str("C");
      calc("9/1", 9, 1'b0, 14);
      wait_done();
      press_str("C");

      calc("1-9", 8, 1'b1, 1);
      wait_done();
      press_str("2");
      check("new_entry_val", disp_val, 2);
      check("new_entry_neg", disp_neg, 0);
      press_str("C");

      calc("9999*9999", 99980001, 1'b0, 1);
      wait_done();
      press_str("C");

      press_str("1234");
      check("four_digits", disp_val, 1234);
      press_str("5");
      check("fifth_ignored", disp_val, 1234);
      press_str("C");

      // Divide by zero: error after one CALC cycle, no done.
      press_str("7/0=");
      check("div0_busy", busy, 1);
      @(negedge clk);
      check("div0_err", err, 1);
      check("div0_val", disp_val, 0);
      check("div0_busy_after", busy, 0);
      repeat (3) @(negedge clk);
      press_str("3");
      check("err_cleared", err, 0);
      check("after_err_val", disp_val, 3);
      press_str("C");

      // Keys (including clear) during a divide must be dropped.
      calc("999/7", 142, 1'b0, 14);
      repeat (2) @(negedge clk);
      check("div_busy", busy, 1);
      press(4'd10);
      press(4'd15);
      check("div_busy_keys", busy, 1);
      wait_done();
      press_str("C");

      // Asynchronous reset mid-divide aborts everything.
      calc("5000/3", 1666, 1'b0, 14);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle("mid_div_reset");
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (16) @(negedge clk);
      check_idle("post_abort");
      press_str("4+");
      check("a_ent_after_reset", disp_val, 4);
      calc("5", 9, 1'b0, 1);
      wait_done();
      press_str("C");

      // Operator replacement in OP_WAIT, then '=' in RESULT is ignored.
      calc("12+-3", 9, 1'b0, 1);
      wait_done();
      press_str("=");
      repeat (2) @(negedge clk);
      check("eq_in_result_val", disp_val, 9);
      check("eq_in_result_done", done, 0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
